// File: rtl/hash_pkg.sv
// Shared types and constants for the hash key arbiter slice.
// Holds the key/length widths, the beat-count helper and the FSM state encoding.
package hash_pkg;

   localparam int unsigned KEY_WIDTH      = 128;
   localparam int unsigned LEN_WIDTH      = 8;
   localparam int unsigned BYTES_PER_BEAT = KEY_WIDTH / 8;
   localparam int unsigned CNT_WIDTH      = 5;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // Number of KEY_WIDTH beats needed to carry len bytes, rounded up.
   function automatic logic [CNT_WIDTH-1:0] beatCount(input logic [LEN_WIDTH-1:0] len);
      logic [LEN_WIDTH:0] sum;
      sum = {1'b0, len} + (LEN_WIDTH+1)'(BYTES_PER_BEAT - 1);
      return CNT_WIDTH'(sum >> $clog2(BYTES_PER_BEAT));
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr, wrapping.
module rr_pick #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned SRC_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]   req,
   input  logic [SRC_WIDTH-1:0] ptr,
   output logic [SRC_WIDTH-1:0] grant,
   output logic                 any
);

   int idx;

   // Scan from the farthest offset down so the nearest request wins last.
   always_comb begin
      grant = '0;
      any   = |req;
      idx   = 0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % int'(NUM_REQ);
         if (req[idx]) begin
            grant = SRC_WIDTH'(idx);
         end
      end
   end

endmodule

// File: rtl/hash_key_arbiter.sv
// Shares one hash engine between NUM_REQ FWFT key sources, one whole key at a time.
// Define HASH_ARB_PRIO0_EN to give source 0 strict priority over the round-robin set.
module hash_key_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned KEY_WIDTH = hash_pkg::KEY_WIDTH,
   parameter int unsigned LEN_WIDTH = hash_pkg::LEN_WIDTH,
   parameter int unsigned SRC_WIDTH = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             iKeyLenEmpty,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]   iKeyLen,
   output logic [NUM_REQ-1:0]             oRdKeyLenFifo_en,
   input  logic [NUM_REQ-1:0]             iKeyEmpty,
   input  logic [NUM_REQ*KEY_WIDTH-1:0]   iKey,
   output logic [NUM_REQ-1:0]             oRdKeyFifo_en,
   output logic                           oHashValid,
   input  logic                           iHashReady,
   output logic [KEY_WIDTH-1:0]           oHashKey,
   output logic                           oHashFirst,
   output logic                           oHashLast,
   output logic [LEN_WIDTH-1:0]           oHashLen,
   output logic [SRC_WIDTH-1:0]           oHashSrc,
   output logic                           oBusy,
   output logic                           oErrZeroLen
);

   import hash_pkg::*;

   state_t                 state;
   logic [SRC_WIDTH-1:0]   ptr;
   logic [CNT_WIDTH-1:0]   cnt;
   logic                   firstFlag;
   logic [NUM_REQ-1:0]     rrReq;
   logic [SRC_WIDTH-1:0]   rrGrant;
   logic                   rrAny;
   logic [SRC_WIDTH-1:0]   grant;
   logic                   anyReq;
   logic [LEN_WIDTH-1:0]   lenG;
   logic                   xfer;

   function automatic logic [SRC_WIDTH-1:0] incPtr(input logic [SRC_WIDTH-1:0] g);
      return (int'(g) == int'(NUM_REQ) - 1) ? '0 : g + 1'b1;
   endfunction

`ifdef HASH_ARB_PRIO0_EN
   // Source 0 bypasses the pointer; the rest rotate among themselves.
   always_comb begin
      rrReq    = ~iKeyLenEmpty;
      rrReq[0] = 1'b0;
      grant    = !iKeyLenEmpty[0] ? '0 : rrGrant;
      anyReq   = !iKeyLenEmpty[0] | rrAny;
   end
`else
   always_comb begin
      rrReq  = ~iKeyLenEmpty;
      grant  = rrGrant;
      anyReq = rrAny;
   end
`endif

   rr_pick #(
      .NUM_REQ   (NUM_REQ),
      .SRC_WIDTH (SRC_WIDTH)
   ) uPick (
      .req   (rrReq),
      .ptr   (ptr),
      .grant (rrGrant),
      .any   (rrAny)
   );

   assign lenG = iKeyLen[grant*LEN_WIDTH +: LEN_WIDTH];

   always_comb begin
      oRdKeyLenFifo_en = '0;
      oRdKeyFifo_en    = '0;
      oHashValid       = 1'b0;
      oHashFirst       = 1'b0;
      oHashLast        = 1'b0;
      oHashKey         = '0;
      xfer             = 1'b0;
      if (state == IDLE) begin
         if (anyReq) begin
            oRdKeyLenFifo_en[grant] = 1'b1;
         end
      end else begin
         oHashValid              = !iKeyEmpty[oHashSrc];
         oHashKey                = iKey[oHashSrc*KEY_WIDTH +: KEY_WIDTH];
         oHashFirst              = firstFlag & oHashValid;
         oHashLast               = (cnt == CNT_WIDTH'(1)) & oHashValid;
         xfer                    = oHashValid & iHashReady;
         oRdKeyFifo_en[oHashSrc] = xfer;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         cnt         <= '0;
         firstFlag   <= 1'b0;
         oHashLen    <= '0;
         oHashSrc    <= '0;
         oBusy       <= 1'b0;
         oErrZeroLen <= 1'b0;
      end else begin
         oErrZeroLen <= 1'b0;
         case (state)
            IDLE: begin
               if (anyReq) begin
                  oHashLen <= lenG;
                  oHashSrc <= grant;
                  // A zero-length entry is popped and reported but never streamed.
                  if (lenG == '0) begin
                     oErrZeroLen <= 1'b1;
                     ptr         <= incPtr(grant);
                  end else begin
                     cnt       <= beatCount(lenG);
                     firstFlag <= 1'b1;
                     oBusy     <= 1'b1;
                     state     <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (xfer) begin
                  cnt       <= cnt - 1'b1;
                  firstFlag <= 1'b0;
                  if (cnt == CNT_WIDTH'(1)) begin
                     ptr   <= incPtr(oHashSrc);
                     oBusy <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hash_key_arbiter.sv
// Scoreboard bench for hash_key_arbiter: FWFT FIFO models feed the DUT, a monitor
// checks every accepted beat against expectations queued by the directed tests.
module tb_hash_key_arbiter;

   localparam int N  = 4;
   localparam int KW = 128;
   localparam int LW = 8;
   localparam int SW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    iKeyLenEmpty, iKeyEmpty, oRdKeyLenFifo_en, oRdKeyFifo_en;
   logic [N*LW-1:0] iKeyLen;
   logic [N*KW-1:0] iKey;
   logic            oHashValid, iHashReady, oHashFirst, oHashLast, oBusy, oErrZeroLen;
   logic [KW-1:0]   oHashKey;
   logic [LW-1:0]   oHashLen;
   logic [SW-1:0]   oHashSrc;

   hash_key_arbiter #(
      .NUM_REQ   (N),
      .KEY_WIDTH (KW),
      .LEN_WIDTH (LW),
      .SRC_WIDTH (SW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .iKeyLenEmpty     (iKeyLenEmpty),
      .iKeyLen          (iKeyLen),
      .oRdKeyLenFifo_en (oRdKeyLenFifo_en),
      .iKeyEmpty        (iKeyEmpty),
      .iKey             (iKey),
      .oRdKeyFifo_en    (oRdKeyFifo_en),
      .oHashValid       (oHashValid),
      .iHashReady       (iHashReady),
      .oHashKey         (oHashKey),
      .oHashFirst       (oHashFirst),
      .oHashLast        (oHashLast),
      .oHashLen         (oHashLen),
      .oHashSrc         (oHashSrc),
      .oBusy            (oBusy),
      .oErrZeroLen      (oErrZeroLen)
   );

   typedef struct packed {
      logic [KW-1:0] key;
      logic          first;
      logic          last;
      logic [SW-1:0] src;
      logic [LW-1:0] len;
   } beat_t;

   beat_t         expQ[$];
   logic [LW-1:0] lenQ[N][$];
   logic [KW-1:0] keyQ[N][$];
   int nCmp = 0, nFail = 0, cyc = 0, errCount = 0, xferCount = 0, lastEndCyc = -1;
   logic [N-1:0] lenPend = '0, keyPend = '0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
      nCmp++;
      if (act !== req) begin
         nFail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   function automatic logic [KW-1:0] wordOf(input int src, input int tag, input int b);
      return {32'(src), 32'(tag), 32'(b), 32'hFACE_0000 ^ 32'(b)};
   endfunction

   function automatic int beatsOf(input int len);
      return (len + 15) / 16;
   endfunction

   task automatic refresh();
      for (int s = 0; s < N; s++) begin
         iKeyLenEmpty[s]     = (lenQ[s].size() == 0);
         iKeyLen[s*LW +: LW] = (lenQ[s].size() != 0) ? lenQ[s][0] : '0;
         iKeyEmpty[s]        = (keyQ[s].size() == 0);
         iKey[s*KW +: KW]    = (keyQ[s].size() != 0) ? keyQ[s][0] : '0;
      end
   endtask

   task automatic loadKey(input int src, input int len, input int tag, input int words);
      lenQ[src].push_back(LW'(len));
      for (int b = 0; b < words; b++) keyQ[src].push_back(wordOf(src, tag, b));
      refresh();
   endtask

   task automatic expKey(input int src, input int len, input int tag);
      int nb;
      nb = beatsOf(len);
      for (int b = 0; b < nb; b++)
         expQ.push_back('{key: wordOf(src, tag, b), first: (b == 0), last: (b == nb - 1),
                          src: SW'(src), len: LW'(len)});
   endtask

   task automatic drain(input string name, input int maxc);
      int n;
      n = 0;
      while ((expQ.size() != 0 || oBusy) && n < maxc) begin
         @(negedge clk);
         n++;
      end
      check({name, "Drain"}, 160'(n < maxc), 160'(1));
      repeat (2) @(negedge clk);
   endtask

   task automatic clearAll();
      for (int s = 0; s < N; s++) begin
         lenQ[s].delete();
         keyQ[s].delete();
      end
      expQ.delete();
      lenPend    = '0;
      keyPend    = '0;
      lastEndCyc = -1;
      refresh();
   endtask

   // Monitor: pops expectations on every accepted beat.
   always @(negedge clk) begin
      beat_t e;
      if (!rst) begin
         if (oErrZeroLen) errCount++;
         for (int s = 0; s < N; s++) begin
            if (oRdKeyLenFifo_en[s]) check("lenPopNonEmpty", 160'(lenQ[s].size() != 0), 160'(1));
            if (oRdKeyFifo_en[s]) check("keyPopNonEmpty", 160'(keyQ[s].size() != 0), 160'(1));
         end
         lenPend = oRdKeyLenFifo_en;
         keyPend = oRdKeyFifo_en;
         if (oHashValid && iHashReady) begin
            xferCount++;
            if (expQ.size() == 0) begin
               nCmp++;
               nFail++;
               $display("FAIL unexpectedBeat: got src %0d key %h, required no beat",
                        oHashSrc, oHashKey);
            end else begin
               e = expQ.pop_front();
               check("beat", {oHashKey, oHashFirst, oHashLast, oHashSrc, oHashLen}, e);
               if (oHashFirst && lastEndCyc >= 0)
                  check("keyGap", 160'((cyc - lastEndCyc) >= 2), 160'(1));
               if (oHashLast) lastEndCyc = cyc;
            end
         end
      end
   end

   // FIFO model: apply pops decided at the previous negedge, then present new heads.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (!rst) begin
         for (int s = 0; s < N; s++) begin
            if (lenPend[s] && lenQ[s].size() != 0) void'(lenQ[s].pop_front());
            if (keyPend[s] && keyQ[s].size() != 0) void'(keyQ[s].pop_front());
         end
      end
      lenPend = '0;
      keyPend = '0;
      refresh();
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, e0, x0;
      iHashReady = 1'b1;
      clearAll();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("resetOutputs", {oHashValid, oHashFirst, oHashLast, oBusy, oErrZeroLen,
            oRdKeyFifo_en, oRdKeyLenFifo_en, oHashLen, oHashSrc}, '0);
      @(posedge clk); #2;
      rst = 1'b0;

      // All four sources, s0 holding a second key.
      @(posedge clk); #2;
      loadKey(0, 16, 1, 1);
      loadKey(1, 16, 2, 1);
      loadKey(2, 16, 3, 1);
      loadKey(3, 16, 4, 1);
      loadKey(0, 16, 5, 1);
`ifdef HASH_ARB_PRIO0_EN
      expKey(0, 16, 1); expKey(0, 16, 5); expKey(1, 16, 2); expKey(2, 16, 3); expKey(3, 16, 4);
`else
      expKey(0, 16, 1); expKey(1, 16, 2); expKey(2, 16, 3); expKey(3, 16, 4); expKey(0, 16, 5);
`endif
      drain("t2", 60);

      // Single source, two beats, checked cycle by cycle.
      @(posedge clk); #2;
      loadKey(1, 20, 10, 2);
      expKey(1, 20, 10);
      @(negedge clk);
      check("t1LenPop", 160'(oRdKeyLenFifo_en), 160'(4'b0010));
      @(negedge clk);
      check("t1FirstBeat", 160'({oHashValid, oHashFirst, oHashLast, oBusy}), 160'(4'b1101));
      drain("t1", 20);

      // 16-beat key with ready toggling.
      x0 = xferCount;
      @(posedge clk); #2;
      loadKey(2, 255, 20, 16);
      expKey(2, 255, 20);
      n = 0;
      while (expQ.size() != 0 && n < 100) begin
         @(posedge clk); #2;
         iHashReady = ~iHashReady;
         n++;
      end
      iHashReady = 1'b1;
      check("t3Done", 160'(n < 100), 160'(1));
      drain("t3", 20);
      check("t3Transfers", 160'(xferCount - x0), 160'(16));

      // Zero-length entry dropped, then a 5-byte key.
      e0 = errCount;
      x0 = xferCount;
      @(posedge clk); #2;
      loadKey(0, 0, 30, 0);
      loadKey(0, 5, 31, 1);
      expKey(0, 5, 31);
      drain("t4", 20);
      check("t4ErrPulses", 160'(errCount - e0), 160'(1));
      check("t4Transfers", 160'(xferCount - x0), 160'(1));

      // Key FIFO underrun mid-key with another source waiting.
      @(posedge clk); #2;
      loadKey(1, 48, 40, 1);
      loadKey(2, 16, 41, 1);
      expKey(1, 48, 40);
      expKey(2, 16, 41);
      n = 0;
      while (!(oHashValid && iHashReady) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t5FirstBeatSeen", 160'(n < 20), 160'(1));
      repeat (10) begin
         @(negedge clk);
         check("t5Gap", 160'({oHashValid, oRdKeyFifo_en, oRdKeyLenFifo_en, oBusy}),
               160'({1'b0, 4'b0000, 4'b0000, 1'b1}));
      end
      @(posedge clk); #2;
      keyQ[1].push_back(wordOf(1, 40, 1));
      keyQ[1].push_back(wordOf(1, 40, 2));
      refresh();
      drain("t5", 30);

      // Reset in the middle of a 4-beat key.
      @(posedge clk); #2;
      loadKey(2, 64, 50, 4);
      expKey(2, 64, 50);
      n = 0;
      while (expQ.size() > 2 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t6MidKey", 160'(n < 20), 160'(1));
      @(posedge clk); #2;
      rst = 1'b1;
      clearAll();
      #1;
      check("t6ResetOutputs", {oHashValid, oHashFirst, oHashLast, oBusy, oErrZeroLen,
            oRdKeyFifo_en, oRdKeyLenFifo_en, oHashLen, oHashSrc}, '0);
      @(posedge clk); #2;
      rst = 1'b0;
      loadKey(3, 16, 60, 1);
      loadKey(0, 16, 61, 1);
      expKey(0, 16, 61);
      expKey(3, 16, 60);
      @(negedge clk);
      check("t6GrantS0", 160'(oRdKeyLenFifo_en), 160'(4'b0001));
      drain("t6", 30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule

// File: doc/hash_key_arbiter.md
Name: hash_key_arbiter

Overview:
- Shares one hash engine (three-hash key pipeline) between NUM_REQ upstream key sources.
- Each source is a pair of first-word-fall-through FIFOs: 128-bit key words plus an 8-bit key length in bytes.
- Grants one source at a time, reads its length entry, then streams exactly ceil(len/16) key words to the hash engine with a valid/ready handshake.
- Tags every key with its source ID so downstream hash results can be routed back to the source.

Parameters:
- NUM_REQ, 4, number of upstream key sources (2..8).
- KEY_WIDTH, 128, key word width in bits; bytes per beat = KEY_WIDTH/8.
- LEN_WIDTH, 8, key length field width (bytes, 0..255).
- SRC_WIDTH, 2, source ID width; must be at least clog2(NUM_REQ).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- iKeyLenEmpty  in  NUM_REQ  per-source length FIFO empty.
- iKeyLen  in  NUM_REQ*LEN_WIDTH  per-source FWFT length head, source s at [s*LEN_WIDTH +: LEN_WIDTH].
- oRdKeyLenFifo_en  out  NUM_REQ  per-source length FIFO pop.
- iKeyEmpty  in  NUM_REQ  per-source key FIFO empty.
- iKey  in  NUM_REQ*KEY_WIDTH  per-source FWFT key word head.
- oRdKeyFifo_en  out  NUM_REQ  per-source key FIFO pop.
- oHashValid  out  1  key beat valid to hash engine.
- iHashReady  in  1  hash engine accepts beat.
- oHashKey  out  KEY_WIDTH  key beat.
- oHashFirst  out  1  first beat of key.
- oHashLast  out  1  last beat of key.
- oHashLen  out  LEN_WIDTH  byte length of current key, held for whole key.
- oHashSrc  out  SRC_WIDTH  source ID of current key, held for whole key.
- oBusy  out  1  high while in STREAM.
- oErrZeroLen  out  1  one-cycle pulse when a zero-length entry is dropped.

Behaviour:
- Reset values:
  - State IDLE; round-robin pointer 0; beat counter 0.
  - Registered oHashLen, oHashSrc, oBusy and oErrZeroLen are 0.
  - Combinational oHashValid, oHashFirst, oHashLast, oRdKeyFifo_en and oRdKeyLenFifo_en are also 0, because they are qualified by state STREAM or IDLE-with-request.
- Beat count: beats = (len + 15) >> 4, 5-bit, range 1..16 for len 1..255.
- IDLE state:
  - Candidates are sources with iKeyLenEmpty = 0.
  - Grant the first candidate at or after the pointer, scanning upward modulo NUM_REQ.
  - In the same cycle: assert oRdKeyLenFifo_en[g]; register len into oHashLen and g into oHashSrc.
  - If len = 0: pulse oErrZeroLen next cycle, pointer <= g+1 (mod NUM_REQ), stay in IDLE.
  - If len != 0: counter <= beats, first flag <= 1, go to STREAM.
  - With no candidates, all outputs stay idle.
- STREAM state (g held):
  - oHashValid = !iKeyEmpty[g]; oHashKey = iKey[g].
  - oHashFirst = first flag & oHashValid.
  - oHashLast = (counter == 1) & oHashValid.
  - Transfer occurs when oHashValid & iHashReady; oRdKeyFifo_en[g] equals the transfer signal.
  - On each transfer: counter decrements and the first flag clears.
  - On the last transfer: pointer <= g+1 (mod NUM_REQ), go to IDLE.
- Latency: 1 cycle from length-FIFO non-empty to first beat valid. A 1-cycle bubble follows every key, so at most 1 key is in flight.
- Stalls:
  - Key FIFO empty mid-key: valid drops and the counter holds. No timeout; other sources wait.
  - iHashReady low: beat, flags and pop are all held.
- No interleaving: a granted key completes before any other source is served.
- Starvation bound: a waiting source is served within NUM_REQ-1 keys.
- Reset mid-key: return to reset state immediately; the partial key is abandoned. Upstream FIFOs are reset on the same rst.
- Pops are never asserted on an empty FIFO.

Optional Feature:
- Macro HASH_ARB_PRIO0_EN.
- When defined: source 0 has strict priority in IDLE whenever its length FIFO is non-empty; the others are served round-robin among themselves.
- When undefined: pure round-robin over all sources.

Decomposition:
- Package hash_pkg: KEY_WIDTH, LEN_WIDTH, BYTES_PER_BEAT, the beat-count function, and state encoding IDLE=0, STREAM=1.
- Sub-module rr_pick: combinational next-grant finder with inputs (request vector, pointer) and outputs (grant index, any).

Test Plan:
1. Single source s1, len 20 (2 beats), iHashReady=1 → len pop in cycle 0; beats in cycles 1-2 with First on beat 1, Last on beat 2, oHashSrc=1, oHashLen=20; two key pops.
2. All 4 sources each hold len 16 → single-beat keys with oHashSrc sequence 0,1,2,3,0 and one idle cycle between keys.
3. s2 len 255 (16 beats), iHashReady toggling every cycle → exactly 16 transfers, Last only on the 16th, key word order preserved.
4. s0 len 0 followed by len 5 → oErrZeroLen pulses once, no beat is emitted for the zero entry, then one 1-beat key is sent.
5. Key FIFO runs empty after beat 1 of a 3-beat key, refills after 10 cycles → valid low during the gap, no pops, and no other source is granted.
6. rst asserted mid-key, then sources 0 and 3 requesting → all outputs drop to 0 immediately; after release s0 is granted first. With HASH_ARB_PRIO0_EN defined and s0 continuously loaded, s0 wins every IDLE cycle.
